// File: rtl/calculator.sv
// calculator: four-function 32-bit unsigned decimal calculator core with edge-detected keypad input.
// Define CALC_DIV_EN to build the divider (opcode 101) and its divide-by-zero ERROR path.
module calculator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr,
  input  logic        clr,
  input  logic [9:0]  btn,
  input  logic [2:0]  opcode,
  output logic        num,
  output logic        op,
  output logic [3:0]  pressedNum,
  output logic [2:0]  pressedOp,
  output logic [2:0]  prevOp,
  output logic [31:0] val1,
  output logic [31:0] val2,
  output logic [31:0] displayedNum,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_OFF    = 4'd0,
    S_READY  = 4'd1,
    S_ENTER  = 4'd2,
    S_OPWAIT = 4'd3,
    S_RESULT = 4'd4,
    S_ERROR  = 4'd5
  } state_e;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_EQ   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_DIV  = 3'd5;

`ifdef CALC_DIV_EN
  localparam logic [2:0] OP_MAX = OP_DIV;
`else
  localparam logic [2:0] OP_MAX = OP_MUL;
`endif

  state_e      state_q, state_d;
  logic [9:0]  btn_q;
  logic [2:0]  opcode_q;
  logic        pwr_q;
  logic        num_q, num_d;
  logic        op_q, op_d;
  logic [3:0]  pressed_num_q, pressed_num_d;
  logic [2:0]  pressed_op_q, pressed_op_d;
  logic [2:0]  prev_op_q, prev_op_d;
  logic [31:0] val1_q, val1_d;
  logic [31:0] val2_q, val2_d;
  logic [31:0] disp_q, disp_d;

  logic        btn_onehot, digit_press, op_press, pwr_rise;
  logic [3:0]  digit;
  logic [31:0] alu_res;
  logic        alu_div0;
  logic        go_zero;

  always_comb begin
    digit = '0;
    for (int i = 0; i < 10; i++) begin
      if (btn[i]) digit = 4'(i);
    end
  end

  assign btn_onehot  = (btn != '0) && ((btn & (btn - 10'd1)) == '0);
  assign op_press    = (opcode >= OP_EQ) && (opcode <= OP_MAX) && (opcode_q == OP_NONE);
  assign digit_press = btn_onehot && (btn_q == '0) && !op_press;
  assign pwr_rise    = pwr && !pwr_q;

  // Left operand is the accumulator, right operand the entry just completed.
  always_comb begin
    alu_res  = val2_q;
    alu_div0 = 1'b0;
    case (prev_op_q)
      OP_ADD: alu_res = val1_q + val2_q;
      OP_SUB: alu_res = val1_q - val2_q;
      OP_MUL: alu_res = val1_q * val2_q;
`ifdef CALC_DIV_EN
      OP_DIV: begin
        alu_div0 = (val2_q == '0);
        alu_res  = alu_div0 ? '0 : val1_q / val2_q;
      end
`endif
      default: alu_res = val2_q;
    endcase
  end

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    num_d         = 1'b0;
    op_d          = 1'b0;
    pressed_num_d = pressed_num_q;
    pressed_op_d  = pressed_op_q;
    prev_op_d     = prev_op_q;
    val1_d        = val1_q;
    val2_d        = val2_q;
    go_zero       = 1'b0;

    if (pwr_rise) begin
      go_zero = 1'b1;
      state_d = (state_q == S_OFF) ? S_READY : S_OFF;
    end else if (state_q == S_OFF) begin
      go_zero = 1'b1;
    end else if (clr) begin
      go_zero = 1'b1;
      state_d = S_READY;
    end else if (op_press) begin
      case (state_q)
        S_ENTER: begin
          op_d         = 1'b1;
          pressed_op_d = opcode;
          val2_d       = '0;
          if (alu_div0) begin
            prev_op_d = OP_NONE;
            state_d   = S_ERROR;
          end else begin
            val1_d    = alu_res;
            prev_op_d = (opcode == OP_EQ) ? OP_NONE : opcode;
            state_d   = (opcode == OP_EQ) ? S_RESULT : S_OPWAIT;
          end
        end
        S_OPWAIT: begin
          op_d         = 1'b1;
          pressed_op_d = opcode;
          prev_op_d    = (opcode == OP_EQ) ? OP_NONE : opcode;
          state_d      = (opcode == OP_EQ) ? S_RESULT : S_OPWAIT;
        end
        S_RESULT: begin
          if (opcode != OP_EQ) begin
            op_d         = 1'b1;
            pressed_op_d = opcode;
            prev_op_d    = opcode;
            state_d      = S_OPWAIT;
          end
        end
        default: ;
      endcase
    end else if (digit_press) begin
      case (state_q)
        S_READY, S_OPWAIT: begin
          num_d         = 1'b1;
          pressed_num_d = digit;
          val2_d        = 32'(digit);
          state_d       = S_ENTER;
        end
        S_ENTER: begin
          num_d         = 1'b1;
          pressed_num_d = digit;
          val2_d        = val2_q * 32'd10 + 32'(digit);
        end
        S_RESULT: begin
          num_d         = 1'b1;
          pressed_num_d = digit;
          val1_d        = '0;
          val2_d        = 32'(digit);
          state_d       = S_ENTER;
        end
        default: ;
      endcase
    end

    if (go_zero) begin
      pressed_num_d = '0;
      pressed_op_d  = OP_NONE;
      prev_op_d     = OP_NONE;
      val1_d        = '0;
      val2_d        = '0;
    end

    case (state_d)
      S_ENTER:            disp_d = val2_d;
      S_OPWAIT, S_RESULT: disp_d = val1_d;
      S_ERROR:            disp_d = '1;
      default:            disp_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_OFF;
      btn_q         <= '0;
      opcode_q      <= OP_NONE;
      pwr_q         <= 1'b0;
      num_q         <= 1'b0;
      op_q          <= 1'b0;
      pressed_num_q <= '0;
      pressed_op_q  <= OP_NONE;
      prev_op_q     <= OP_NONE;
      val1_q        <= '0;
      val2_q        <= '0;
      disp_q        <= '0;
    end else begin
      state_q       <= state_d;
      btn_q         <= btn;
      opcode_q      <= opcode;
      pwr_q         <= pwr;
      num_q         <= num_d;
      op_q          <= op_d;
      pressed_num_q <= pressed_num_d;
      pressed_op_q  <= pressed_op_d;
      prev_op_q     <= prev_op_d;
      val1_q        <= val1_d;
      val2_q        <= val2_d;
      disp_q        <= disp_d;
    end
  end

  assign state        = state_q;
  assign num          = num_q;
  assign op           = op_q;
  assign pressedNum   = pressed_num_q;
  assign pressedOp    = pressed_op_q;
  assign prevOp       = prev_op_q;
  assign val1         = val1_q;
  assign val2         = val2_q;
  assign displayedNum = disp_q;

endmodule

// File: tb/tb_calculator.sv
// tb_calculator: directed test-plan sequences plus randomized keypad traffic, scored against
// a behavioural calculator model through an expected-response queue.
module tb_calculator;

  localparam int M_OFF = 0, M_READY = 1, M_ENTER = 2, M_OPWAIT = 3, M_RESULT = 4, M_ERROR = 5;
  localparam longint unsigned TWO32 = 64'h1_0000_0000;
`ifdef CALC_DIV_EN
  localparam int MAX_OP = 5;
`else
  localparam int MAX_OP = 4;
`endif

  typedef struct {
    logic [3:0]  st;
    logic [31:0] disp, v1, v2;
    logic [2:0]  prev, pop;
    logic [3:0]  pnum;
    logic        n, o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, pwr, clr;
  logic [9:0]  btn;
  logic [2:0]  opcode;
  logic        num, op;
  logic [3:0]  pressedNum, state;
  logic [2:0]  pressedOp, prevOp;
  logic [31:0] val1, val2, displayedNum;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  int               m_state = M_OFF;
  longint unsigned  m_val1 = 0, m_val2 = 0;
  int               m_prev = 0, m_pnum = 0, m_pop = 0;
  bit               m_num = 0, m_op = 0;
  bit [9:0]         p_btn = '0;
  bit [2:0]         p_opc = '0;
  bit               p_pwr = 1'b0;

  calculator dut (
    .clk(clk), .rst_n(rst_n), .pwr(pwr), .clr(clr), .btn(btn), .opcode(opcode),
    .num(num), .op(op), .pressedNum(pressedNum), .pressedOp(pressedOp), .prevOp(prevOp),
    .val1(val1), .val2(val2), .displayedNum(displayedNum), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned arith(input longint unsigned a, input int o,
                                            input longint unsigned b);
    case (o)
      2:       return (a + b) % TWO32;
      3:       return (a + TWO32 - b) % TWO32;
      4:       return (a * b) % TWO32;
      5:       return a / b;
      default: return b;
    endcase
  endfunction

  task automatic model_clear();
    m_val1 = 0; m_val2 = 0; m_prev = 0; m_pnum = 0; m_pop = 0;
  endtask

  // One clock edge of the calculator as described by its operating rules.
  task automatic model_step(input bit rs, input bit pw, input bit cl, input bit [9:0] b,
                            input bit [2:0] oc);
    bit op_hit, dig_hit;
    int d;
    m_num = 0;
    m_op  = 0;
    if (!rs) begin
      model_clear();
      m_state = M_OFF;
      p_btn = '0; p_opc = '0; p_pwr = 1'b0;
      return;
    end
    op_hit = (oc >= 1) && (oc <= MAX_OP) && (p_opc == 0);
    d = -1;
    if ($countones(b) == 1)
      for (int i = 0; i < 10; i++) if (b[i]) d = i;
    dig_hit = (d >= 0) && (p_btn == 0) && !op_hit;
    if (pw && !p_pwr) begin
      model_clear();
      m_state = (m_state == M_OFF) ? M_READY : M_OFF;
    end else if (m_state == M_OFF) begin
      model_clear();
    end else if (cl) begin
      model_clear();
      m_state = M_READY;
    end else if (op_hit) begin
      if (m_state == M_ENTER || m_state == M_OPWAIT) begin
        m_op = 1; m_pop = oc;
        if (m_state == M_ENTER) begin
          if (m_prev == 5 && m_val2 == 0) m_state = M_ERROR;
          else m_val1 = (m_prev == 0) ? m_val2 : arith(m_val1, m_prev, m_val2);
          m_val2 = 0;
        end
        if (m_state != M_ERROR) begin
          m_prev  = (oc == 1) ? 0 : int'(oc);
          m_state = (oc == 1) ? M_RESULT : M_OPWAIT;
        end
      end else if (m_state == M_RESULT && oc != 1) begin
        m_op = 1; m_pop = oc; m_prev = oc; m_state = M_OPWAIT;
      end
    end else if (dig_hit && m_state != M_ERROR) begin
      m_num = 1; m_pnum = d;
      if (m_state == M_ENTER) m_val2 = (m_val2 * 10 + longint'(d)) % TWO32;
      else m_val2 = d;
      if (m_state == M_RESULT) m_val1 = 0;
      m_state = M_ENTER;
    end
    p_btn = b; p_opc = oc; p_pwr = pw;
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.st   = 4'(m_state);
    e.v1   = 32'(m_val1);
    e.v2   = 32'(m_val2);
    e.prev = 3'(m_prev);
    e.pop  = 3'(m_pop);
    e.pnum = 4'(m_pnum);
    e.n    = m_num;
    e.o    = m_op;
    case (m_state)
      M_ENTER:            e.disp = 32'(m_val2);
      M_OPWAIT, M_RESULT: e.disp = 32'(m_val1);
      M_ERROR:            e.disp = 32'hFFFF_FFFF;
      default:            e.disp = 32'h0;
    endcase
    return e;
  endfunction

  // Drive one cycle of inputs away from the active edge and queue the expected response.
  task automatic step(input bit rs, input bit pw, input bit cl, input bit [9:0] b,
                      input bit [2:0] oc);
    @(negedge clk);
    rst_n = rs; pwr = pw; clr = cl; btn = b; opcode = oc;
    model_step(rs, pw, cl, b, oc);
    exp_q.push_back(snapshot());
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic press_d(input int d);
    step(1, 0, 0, 10'(1) << d, 0);
    step(1, 0, 0, 10'h0, 0);
  endtask

  task automatic press_o(input bit [2:0] o);
    step(1, 0, 0, 10'h0, o);
    step(1, 0, 0, 10'h0, 0);
  endtask

  task automatic do_clr();
    step(1, 0, 1, 10'h0, 0);
    step(1, 0, 0, 10'h0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_state", 32'(state), 32'(e.st));
        check("sb_disp", displayedNum, e.disp);
        check("sb_num", 32'(num), 32'(e.n));
        check("sb_op", 32'(op), 32'(e.o));
        check("sb_pnum", 32'(pressedNum), 32'(e.pnum));
        check("sb_pop", 32'(pressedOp), 32'(e.pop));
        if (e.st != 4'(M_ERROR)) begin
          check("sb_prev", 32'(prevOp), 32'(e.prev));
          check("sb_val1", val1, e.v1);
          check("sb_val2", val2, e.v2);
        end
      end
    end
  end

  initial begin : stimulus
    int       cnt;
    bit       r_pwr;
    bit [9:0] r_btn;
    bit [2:0] r_opc;
    rst_n = 1'b0; pwr = 1'b0; clr = 1'b0; btn = '0; opcode = '0;
    repeat (3) step(0, 0, 0, 10'h0, 0);
    settle();
    check("reset_state", 32'(state), 32'd0);
    check("reset_disp", displayedNum, 32'd0);

    step(1, 1, 0, 10'h0, 0);
    step(1, 0, 0, 10'h0, 0);
    settle();
    check("pwr_on_state", 32'(state), 32'd1);

    press_d(3); press_o(3'd2); press_d(3); press_o(3'd2); press_d(3); press_o(3'd1);
    settle();
    check("sum9_val1", val1, 32'd9);
    check("sum9_disp", displayedNum, 32'd9);
    check("sum9_state", 32'(state), 32'd4);
    check("sum9_prev", 32'(prevOp), 32'd0);

    press_o(3'd2); press_d(3); press_o(3'd1);
    settle();
    check("chain12_disp", displayedNum, 32'd12);

    do_clr();
    settle();
    check("clr_state", 32'(state), 32'd1);
    check("clr_val1", val1, 32'd0);
    check("clr_val2", val2, 32'd0);

    press_d(5); press_d(0); press_o(3'd4); press_d(1); press_d(0); press_o(3'd1);
    settle();
    check("mul500_disp", displayedNum, 32'd500);
    do_clr();
    press_d(5); press_d(0); press_o(3'd3); press_d(1); press_d(0); press_o(3'd1);
    settle();
    check("sub40_disp", displayedNum, 32'd40);
    do_clr();
    press_d(5); press_o(3'd3); press_d(7); press_o(3'd1);
    settle();
    check("sub_wrap_disp", displayedNum, 32'hFFFF_FFFE);

    do_clr();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 10'h010, 0);
      settle();
      cnt += int'(num);
    end
    check("hold_num_count", 32'(cnt), 32'd1);
    check("hold_val2", val2, 32'd4);
    step(1, 0, 0, 10'h0, 0);
    step(1, 0, 0, 10'h003, 0);
    settle();
    check("multihot_num", 32'(num), 32'd0);
    check("multihot_val2", val2, 32'd4);
    step(1, 0, 0, 10'h0, 0);

`ifdef CALC_DIV_EN
    do_clr();
    press_d(7); press_o(3'd5); press_d(2); press_o(3'd1);
    settle();
    check("div3_disp", displayedNum, 32'd3);
    do_clr();
    press_d(7); press_o(3'd5); press_d(0); press_o(3'd1);
    settle();
    check("div0_state", 32'(state), 32'd5);
    check("div0_disp", displayedNum, 32'hFFFF_FFFF);
    press_d(9);
    settle();
    check("err_hold_state", 32'(state), 32'd5);
    do_clr();
    settle();
    check("err_clr_state", 32'(state), 32'd1);
`else
    do_clr();
    press_d(7); press_o(3'd5);
    settle();
    check("nodiv_state", 32'(state), 32'd2);
    check("nodiv_prev", 32'(prevOp), 32'd0);
`endif

    press_d(8);
    step(1, 1, 0, 10'h0, 0);
    step(1, 0, 0, 10'h0, 0);
    settle();
    check("pwr_off_state", 32'(state), 32'd0);
    check("pwr_off_disp", displayedNum, 32'd0);
    press_d(5);
    settle();
    check("off_digit_val2", val2, 32'd0);
    check("off_digit_state", 32'(state), 32'd0);
    step(1, 1, 0, 10'h0, 0);
    step(1, 0, 0, 10'h0, 0);
    settle();
    check("pwr_on2_state", 32'(state), 32'd1);

    r_pwr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) r_pwr = !r_pwr;
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9: r_btn = '0;
        10, 11, 12, 13, 14, 15, 16:   r_btn = 10'(1) << $urandom_range(0, 9);
        default:                      r_btn = 10'($urandom);
      endcase
      r_opc = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(1, 7));
      step(($urandom_range(0, 499) != 0), r_pwr, ($urandom_range(0, 39) == 0), r_btn, r_opc);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calculator.md
# calculator

Four-function, 32-bit unsigned decimal calculator core. It sits between the keypad/operator-button front end and the display driver. It edge-detects one-hot digit buttons and operator codes, accumulates a decimal entry, applies operators left-to-right without precedence, and exposes the value to show plus internal debug state.

## Interface
Parameters: none.

- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `pwr`  in  1  power toggle; each rising edge flips ON/OFF.
- `clr`  in  1  clear (level); while high and ON, returns to READY with zeroed values.
- `btn`  in  10  digit buttons; bit d = digit d, must be one-hot.
- `opcode`  in  3  operator: 000 none, 001 EQ, 010 ADD, 011 SUB, 100 MUL, 101 DIV, 110/111 ignored.
- `num`  out  1  one-cycle pulse: digit accepted.
- `op`  out  1  one-cycle pulse: operator accepted.
- `pressedNum`  out  4  last accepted digit.
- `pressedOp`  out  3  last accepted opcode.
- `prevOp`  out  3  pending operator (000 = none).
- `val1`  out  32  accumulator.
- `val2`  out  32  current entry.
- `displayedNum`  out  32  value to display.
- `state`  out  4  FSM state.

## Operation
- Registers `btn_q` and `opcode_q` hold the previous-cycle inputs. A digit press is a cycle where `btn` is one-hot and `btn_q` is 0. An operator press is a cycle where `opcode` is 001..101 and `opcode_q` is 000. Non-one-hot `btn` is ignored.
- Priority, highest first: `rst_n` low, `pwr` rising edge, `clr`, operator press, digit press. A digit press in the same cycle as an operator press is dropped.
- FSM states:
  - OFF=0: all values 0. Only a `pwr` edge acts; it clears everything and goes to READY.
  - READY=1: digit d sets val2=d and goes to ENTER. Operators are ignored.
  - ENTER=2: digit sets val2=val2*10+d.
    - ADD/SUB/MUL/DIV: val1 = (prevOp==000 ? val2 : val1 prevOp val2); prevOp=opcode; val2=0; go to OPWAIT.
    - EQ: the same compute, then prevOp=000, val2=0; go to RESULT.
  - OPWAIT=3: digit sets val2=d and goes to ENTER. Another operator replaces prevOp. EQ sets prevOp=000 and goes to RESULT with val1 unchanged.
  - RESULT=4: operator sets prevOp=opcode and goes to OPWAIT, chaining on the result. EQ does nothing. A digit sets val1=0, val2=d and goes to ENTER.
  - ERROR=5: only `clr` (to READY) or `pwr` (to OFF) exits.
- In any ON state, a `pwr` rising edge goes to OFF and zeroes all outputs.
- Arithmetic:
  - Everything is 32-bit unsigned and wraps modulo 2^32, including digit accumulation.
  - SUB is two's-complement wrap: 5-7 = 0xFFFFFFFE.
  - MUL keeps the low 32 bits.
  - DIV truncates. Dividing by zero sends the FSM to ERROR.
- displayedNum:
  - ENTER: val2.
  - OPWAIT and RESULT: val1.
  - READY and OFF: 0.
  - ERROR: 0xFFFFFFFF.
- pressedNum and pressedOp update on every accepted press and hold otherwise. All are cleared by OFF, `clr` and reset.

## Timing
- Every output is a register. An input change sampled at edge k appears in the outputs after edge k, so latency is 1 clock.
- num and op are high for exactly one cycle per press, no matter how long the input is held.
- Reset (`rst_n`=0 at an edge): state=OFF, prevOp=000, and every other output is 0. The input-history registers also clear, so an input already held at reset release does not produce an edge.
- `clr` takes effect at every edge where it is high. Presses during `clr` are discarded. A button still held when `clr` drops does not re-fire.
- A reset in the middle of an operation discards all pending values.

## Configuration
- `CALC_DIV_EN` defined: opcode 101 is DIV with the divide-by-zero ERROR path, using a combinational or iterative divider that meets the 1-cycle latency.
- Not defined: opcode 101 is ignored like 110/111, no divider is built, and ERROR is unreachable.

## Test plan
- Reset, `pwr` pulse → state=1. Press 3, ADD, 3, ADD, 3, EQ → val1=9, displayedNum=9, state=4, prevOp=000.
- From that result, ADD, 3, EQ → displayedNum=12. Then `clr` → state=1, val1=val2=0.
- Press 5, 0, MUL, 1, 0, EQ → 500. The same sequence with SUB → 40. 5 SUB 7 EQ → 0xFFFFFFFE.
- Hold a digit for 10 cycles → num high exactly 1 cycle, val2 updated once. `btn`=0x003 → ignored.
- With `CALC_DIV_EN`: 7 DIV 2 EQ → 3. 7 DIV 0 EQ → state=5, displayedNum=0xFFFFFFFF, digits ignored until `clr`.
- A `pwr` edge while ON → state=0, all outputs 0, digit presses ignored. A second `pwr` edge → state=1.
